spi_reg_frontend: RTL and testbench

SPI slave command decoder that drives the register bank's host-side interface: address, write data, read/write strobes, and read data back. It oversamples the external SPI pins (mode 0, MSB first) on SPI_CLK, decodes command frames and issues single-cycle strobes. Read data is returned on MISO. It sits between the chip's SPI pads and the register bank, in the SPI_CLK domain.

---
 rtl/spi_reg_frontend.sv | 199 +++++++++++++++++++
 tb/tb_spi_reg_frontend.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_frontend.sv
`default_nettype none
// ============================================================================
// Module   : spi_reg_frontend
// Brief    : SPI mode-0 slave that decodes READ/WRITE command frames into
//            register-bank strobes. Optional build macro: SPI_AUTOINC_EN.
// Revision : 1.0 - initial release
// ============================================================================
module spi_reg_frontend #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  SPI_CLK,
    input  logic                  RST,
    input  logic                  SCLK,
    input  logic                  CS_N,
    input  logic                  MOSI,
    output logic                  MISO,
    output logic [ADDR_WIDTH-1:0] reg_address,
    output logic [DATA_WIDTH-1:0] reg_wdata,
    output logic                  reg_write_strobe,
    output logic                  reg_read_strobe,
    input  logic [DATA_WIDTH-1:0] reg_rdata,
    output logic                  frame_active
);

    localparam int c_CNT_W = $clog2(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] c_OP_READ  = DATA_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] c_OP_WRITE = DATA_WIDTH'(2);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_CMD    = 3'd1;
    localparam logic [2:0] c_ADDR_W = 3'd2;
    localparam logic [2:0] c_WDATA  = 3'd3;
    localparam logic [2:0] c_ADDR_R = 3'd4;
    localparam logic [2:0] c_RDUMMY = 3'd5;
    localparam logic [2:0] c_RDATA  = 3'd6;
    localparam logic [2:0] c_IGNORE = 3'd7;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_d;
    logic [c_CNT_W-1:0]     r_bit_cnt;
    logic [DATA_WIDTH-1:0]  r_rx;
    logic [2:0]             r_state;
    logic [2:0]             w_state_nxt;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [DATA_WIDTH-1:0]  r_wdata;
    logic                   r_write_strobe;
    logic                   r_read_strobe;
    logic                   r_rd_pending;
    logic [DATA_WIDTH-1:0]  r_rd_hold;
    logic [DATA_WIDTH-1:0]  r_tx;
    logic                   r_miso;

    logic                   w_sclk_s;
    logic                   w_mosi_s;
    logic                   w_cs_active;
    logic                   w_sclk_rise;
    logic                   w_sclk_fall;
    logic [DATA_WIDTH-1:0]  w_byte;
    logic                   w_byte_done;
    logic                   w_addr_hit;
    logic                   w_wr_hit;
    logic                   w_rd_first;
    logic                   w_rd_next;
    logic                   w_tx_shift;

    // Chip select resets to the inactive (high) level in its synchroniser.
    always_ff @(posedge SPI_CLK or posedge RST) begin
        if (RST) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_d    <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SCLK};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], CS_N};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
            r_sclk_d    <= w_sclk_s;
        end
    end

    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
    assign w_cs_active = ~r_cs_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_cs_active & w_sclk_s & ~r_sclk_d;
    assign w_sclk_fall = w_cs_active & ~w_sclk_s & r_sclk_d;
    assign w_byte      = {r_rx[DATA_WIDTH-2:0], w_mosi_s};
    assign w_byte_done = w_sclk_rise & (r_bit_cnt == c_CNT_W'(DATA_WIDTH-1));
    assign w_addr_hit  = w_byte_done & ((r_state == c_ADDR_W) | (r_state == c_ADDR_R));
    assign w_wr_hit    = w_byte_done & (r_state == c_WDATA);
    assign w_rd_first  = w_byte_done & (r_state == c_ADDR_R);
    assign w_rd_next   = w_byte_done & ((r_state == c_RDUMMY) | (r_state == c_RDATA));
    assign w_tx_shift  = w_sclk_fall & (r_state == c_RDATA);

    // Deasserted chip select discards any partially received byte.
    always_ff @(posedge SPI_CLK or posedge RST) begin
        if (RST) begin
            r_bit_cnt <= '0;
            r_rx      <= '0;
        end else if (!w_cs_active) begin
            r_bit_cnt <= '0;
            r_rx      <= '0;
        end else if (w_sclk_rise) begin
            r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
            r_rx      <= w_byte;
        end
    end

    always_ff @(posedge SPI_CLK or posedge RST) begin
        if (RST) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!w_cs_active) begin
            w_state_nxt = c_IDLE;
        end else begin
            case (r_state)
                c_IDLE:   w_state_nxt = c_CMD;
                c_CMD: begin
                    if (w_byte_done) begin
                        if (w_byte == c_OP_WRITE) begin
                            w_state_nxt = c_ADDR_W;
                        end else if (w_byte == c_OP_READ) begin
                            w_state_nxt = c_ADDR_R;
                        end else begin
                            w_state_nxt = c_IGNORE;
                        end
                    end
                end
                c_ADDR_W: if (w_byte_done) w_state_nxt = c_WDATA;
                c_ADDR_R: if (w_byte_done) w_state_nxt = c_RDUMMY;
                c_RDUMMY: if (w_byte_done) w_state_nxt = c_RDATA;
                default:  w_state_nxt = r_state;
            endcase
        end
    end

    // Read path prefetches: each data-phase byte boundary ships the held word
    // and launches the read that will feed the following byte.
    always_ff @(posedge SPI_CLK or posedge RST) begin
        if (RST) begin
            r_addr         <= '0;
            r_wdata        <= '0;
            r_write_strobe <= 1'b0;
            r_read_strobe  <= 1'b0;
            r_rd_pending   <= 1'b0;
            r_rd_hold      <= '0;
            r_tx           <= '0;
            r_miso         <= 1'b0;
        end else begin
            r_write_strobe <= w_wr_hit;
            r_read_strobe  <= w_rd_first | w_rd_next;
            r_rd_pending   <= r_read_strobe;
            if (w_addr_hit) begin
                r_addr <= ADDR_WIDTH'(w_byte);
            end
`ifdef SPI_AUTOINC_EN
            else if (r_write_strobe || w_rd_next) begin
                r_addr <= r_addr + ADDR_WIDTH'(1);
            end
`endif
            if (w_wr_hit) begin
                r_wdata <= w_byte;
            end
            if (r_rd_pending) begin
                r_rd_hold <= reg_rdata;
            end
            if (w_rd_next) begin
                r_tx <= r_rd_hold;
            end else if (w_tx_shift) begin
                r_tx <= r_tx << 1;
            end
            if (!w_cs_active) begin
                r_miso <= 1'b0;
            end else if (w_tx_shift) begin
                r_miso <= r_tx[DATA_WIDTH-1];
            end
        end
    end

    always_comb begin
        frame_active     = (r_state != c_IDLE);
        MISO             = r_miso & (r_state == c_RDATA) & ~CS_N;
        reg_address      = r_addr;
        reg_wdata        = r_wdata;
        reg_write_strobe = r_write_strobe;
        reg_read_strobe  = r_read_strobe;
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_frontend.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_reg_frontend
// Brief    : Randomised frame bench for spi_reg_frontend with a frame-level
//            reference model and register-bank model. Honours SPI_AUTOINC_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_reg_frontend;

`ifdef SPI_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif
    localparam int H = 8;  // SCLK half period in SPI_CLK cycles

    logic       SPI_CLK = 1'b0;
    logic       RST     = 1'b1;
    logic       SCLK    = 1'b0;
    logic       CS_N    = 1'b1;
    logic       MOSI    = 1'b0;
    logic       MISO;
    logic [7:0] reg_address;
    logic [7:0] reg_wdata;
    logic       reg_write_strobe;
    logic       reg_read_strobe;
    logic [7:0] reg_rdata = 8'h00;
    logic       frame_active;

    logic [7:0]  mem  [256];
    logic [7:0]  snap [256];
    logic [15:0] wr_q [$];
    logic [7:0]  rd_q [$];
    logic [7:0]  fr       [8];
    logic [7:0]  miso_got [8];
    int          fr_n;
    int          n_checks = 0;
    int          n_errors = 0;

    spi_reg_frontend #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (8),
        .SYNC_STAGES(2)
    ) dut (
        .SPI_CLK         (SPI_CLK),
        .RST             (RST),
        .SCLK            (SCLK),
        .CS_N            (CS_N),
        .MOSI            (MOSI),
        .MISO            (MISO),
        .reg_address     (reg_address),
        .reg_wdata       (reg_wdata),
        .reg_write_strobe(reg_write_strobe),
        .reg_read_strobe (reg_read_strobe),
        .reg_rdata       (reg_rdata),
        .frame_active    (frame_active)
    );

    always #5 SPI_CLK = ~SPI_CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Register bank: registered read data one cycle after the strobe.
    always @(posedge SPI_CLK) begin
        if (reg_read_strobe) reg_rdata <= mem[reg_address];
        if (reg_write_strobe) mem[reg_address] = reg_wdata;
    end

    always @(negedge SPI_CLK) begin
        if (!RST) begin
            if (reg_write_strobe) wr_q.push_back({reg_address, reg_wdata});
            if (reg_read_strobe) rd_q.push_back(reg_address);
            if (reg_write_strobe || reg_read_strobe)
                check("rw_excl", {31'd0, reg_write_strobe & reg_read_strobe}, 32'd0);
        end
    end

    task automatic clks(input int n);
        repeat (n) @(posedge SPI_CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int nbits, output logic [7:0] mb);
        mb = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            MOSI = b[7-i];
            clks(H);
            mb = {mb[6:0], MISO};
            SCLK = 1'b1;
            clks(H);
            SCLK = 1'b0;
        end
    endtask

    // Expected behaviour derived from frame contents alone.
    task automatic score();
        int         nw;
        int         nr;
        logic [7:0] ea;
        logic [7:0] ed;
        nw = (fr_n >= 2 && fr[0] == 8'h02) ? fr_n - 2 : 0;
        nr = (fr_n >= 2 && fr[0] == 8'h01) ? fr_n - 1 : 0;
        check("wr_count", wr_q.size(), nw);
        for (int i = 0; i < nw && i < wr_q.size(); i++) begin
            ea = fr[1] + (AUTOINC ? 8'(i) : 8'd0);
            check("wr_addr", {24'd0, wr_q[i][15:8]}, {24'd0, ea});
            check("wr_data", {24'd0, wr_q[i][7:0]}, {24'd0, fr[i+2]});
        end
        check("rd_count", rd_q.size(), nr);
        for (int j = 0; j < nr && j < rd_q.size(); j++) begin
            ea = fr[1] + (AUTOINC ? 8'(j) : 8'd0);
            check("rd_addr", {24'd0, rd_q[j]}, {24'd0, ea});
        end
        for (int k = 0; k < fr_n; k++) begin
            ed = 8'h00;
            if (fr[0] == 8'h01 && k >= 3) begin
                ea = fr[1] + (AUTOINC ? 8'(k - 3) : 8'd0);
                ed = snap[ea];
            end
            check("miso_byte", {24'd0, miso_got[k]}, {24'd0, ed});
        end
    endtask

    task automatic run_frame();
        logic [7:0] mb;
        snap = mem;
        wr_q.delete();
        rd_q.delete();
        CS_N = 1'b0;
        clks(H);
        for (int k = 0; k < fr_n; k++) begin
            send_byte(fr[k], 8, mb);
            miso_got[k] = mb;
            if (k == 0) check("fa_active", {31'd0, frame_active}, 32'd1);
        end
        clks(H);
        CS_N = 1'b1;
        clks(H);
        check("fa_idle", {31'd0, frame_active}, 32'd0);
        score();
    endtask

    task automatic set_frame(input int n, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] b4);
        fr_n  = n;
        fr[0] = b0; fr[1] = b1; fr[2] = b2; fr[3] = b3; fr[4] = b4;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] mb;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

        clks(3);
        check("rst_addr",  {24'd0, reg_address}, 32'd0);
        check("rst_wdata", {24'd0, reg_wdata}, 32'd0);
        check("rst_ws",    {31'd0, reg_write_strobe}, 32'd0);
        check("rst_rs",    {31'd0, reg_read_strobe}, 32'd0);
        check("rst_fa",    {31'd0, frame_active}, 32'd0);
        check("rst_miso",  {31'd0, MISO}, 32'd0);
        RST = 1'b0;
        clks(4);

        set_frame(3, 8'h02, 8'h03, 8'h5A, 8'h00, 8'h00); run_frame();
        mem[5] = 8'h11;
        set_frame(4, 8'h01, 8'h05, 8'h00, 8'h00, 8'h00); run_frame();
        set_frame(5, 8'h02, 8'hFE, 8'hAA, 8'hBB, 8'hCC); run_frame();
        set_frame(4, 8'h7F, 8'h12, 8'h34, 8'h56, 8'h00); run_frame();
        set_frame(3, 8'h02, 8'h44, 8'hE7, 8'h00, 8'h00); run_frame();
        set_frame(5, 8'h01, 8'hFF, 8'h00, 8'h00, 8'h00); run_frame();

        // Chip select released after 5 bits of a data byte.
        wr_q.delete();
        rd_q.delete();
        CS_N = 1'b0;
        clks(H);
        send_byte(8'h02, 8, mb);
        send_byte(8'h10, 8, mb);
        send_byte(8'hC3, 5, mb);
        CS_N = 1'b1;
        repeat (3) @(posedge SPI_CLK);
        #1;
        check("partial_fa", {31'd0, frame_active}, 32'd0);
        clks(H);
        check("partial_wr", wr_q.size(), 0);
        check("partial_rd", rd_q.size(), 0);

        // Reset in the middle of a read data byte.
        mem[8'h40] = 8'hFF;
        mem[8'h41] = 8'hFF;
        CS_N = 1'b0;
        clks(H);
        send_byte(8'h01, 8, mb);
        send_byte(8'h40, 8, mb);
        send_byte(8'h00, 8, mb);
        send_byte(8'h00, 3, mb);
        clks(4);
        check("pre_rst_miso", {31'd0, MISO}, 32'd1);
        check("pre_rst_fa",   {31'd0, frame_active}, 32'd1);
        @(posedge SPI_CLK);
        #3;
        RST = 1'b1;
        #1;
        check("arst_miso", {31'd0, MISO}, 32'd0);
        check("arst_fa",   {31'd0, frame_active}, 32'd0);
        check("arst_ws",   {31'd0, reg_write_strobe}, 32'd0);
        check("arst_rs",   {31'd0, reg_read_strobe}, 32'd0);
        check("arst_addr", {24'd0, reg_address}, 32'd0);
        CS_N = 1'b1;
        SCLK = 1'b0;
        clks(3);
        RST = 1'b0;
        clks(4);
        set_frame(3, 8'h02, 8'h21, 8'h9C, 8'h00, 8'h00); run_frame();
        set_frame(4, 8'h01, 8'h21, 8'h00, 8'h00, 8'h00); run_frame();

        for (int t = 0; t < 20; t++) begin
            case ($urandom_range(0, 2))
                0:       fr[0] = 8'h02;
                1:       fr[0] = 8'h01;
                default: fr[0] = 8'($urandom_range(3, 255));
            endcase
            fr_n  = $urandom_range(2, 5);
            fr[1] = ($urandom_range(0, 3) == 0) ? 8'hFE : 8'($urandom);
            for (int k = 2; k < 5; k++) fr[k] = 8'($urandom);
            run_frame();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
